// File: rtl/alu_seq.sv
// alu_seq: registered ALU with add/sub/logic/shift ops and an optional
// multi-cycle unsigned shift-add multiply behind a start/done handshake.
// Ports: clk, clr_n (async active-low), a/b operands, op select, start,
//   en (tri-state ans enable), flag_en; outputs ans, busy, done and the
//   carry/is_zero/negative/overflow flag register.
// Macro ALU_MUL_EN: defined = op 111 is multi-cycle multiply;
//   undefined = op 111 passes b in one cycle and busy is tied low.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             en,
    input  logic             flag_en,
    output logic [WIDTH-1:0] ans,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             is_zero,
    output logic             negative,
    output logic             overflow
);

    if (WIDTH < 4 || (2 ** CNT_W) <= WIDTH) begin : g_param_chk
        $error("alu_seq: WIDTH must be >= 4 and 2**CNT_W > WIDTH");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    // Single-cycle datapath
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign add_ext = {1'b0, a} + {1'b0, b};
    // Carry out of a + ~b + 1 is the inverted borrow (1 when a >= b)
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_c   = a[WIDTH-1];
                alu_v   = a[WIDTH-1] ^ a[WIDTH-2];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            // Pass-through of b; only reaches the result when the
            // multiplier is not built in.
            OP_MUL: alu_res = b;
        endcase
    end

`ifdef ALU_MUL_EN
    // Multiplicand shifts left and multiplier shifts right each step,
    // so only bit 0 of the multiplier is ever inspected.
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_sum;

    assign prod_sum = prod_q + (mplr_q[0] ? mcand_q : '0);
`endif

    logic             load;
    logic [WIDTH-1:0] ld_res;
    logic             ld_c;
    logic             ld_v;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        ld_res   = alu_res;
        ld_c     = alu_c;
        ld_v     = alu_v;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
`ifdef ALU_MUL_EN
            S_MUL: begin
                prod_d  = prod_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    ld_res  = prod_sum[WIDTH-1:0];
                    ld_c    = |prod_sum[2*WIDTH-1:WIDTH];
                    ld_v    = 1'b0;
                end
            end
`endif
            default: begin
                if (start) begin
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) begin
                        state_d = S_MUL;
                        mcand_d = {{WIDTH{1'b0}}, a};
                        mplr_d  = b;
                        prod_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        load    = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    load    = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (load) begin
            result_d = ld_res;
            if (flag_en) begin
                carry_d = ld_c;
                zero_d  = (ld_res == '0);
                neg_d   = ld_res[WIDTH-1];
                ovf_d   = ld_v;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_MUL);
`else
    assign busy = 1'b0;
`endif

    assign done     = (state_q == S_DONE);
    assign ans      = en ? result_q : {WIDTH{1'bz}};
    assign carry    = carry_q;
    assign is_zero  = zero_q;
    assign negative = neg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven self-checking bench for alu_seq
// (WIDTH=8); multiply sequences are included when ALU_MUL_EN is defined.
module tb_alu_seq;

    logic       clk;
    logic       clr_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       start;
    logic       en;
    logic       flag_en;
    wire  [7:0] ans;
    logic       busy;
    logic       done;
    logic       carry;
    logic       is_zero;
    logic       negative;
    logic       overflow;

    int n_chk;
    int n_fail;

    alu_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .start    (start),
        .en       (en),
        .flag_en  (flag_en),
        .ans      (ans),
        .busy     (busy),
        .done     (done),
        .carry    (carry),
        .is_zero  (is_zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [3:0] flags = {carry, is_zero, negative, overflow};

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fe;
        logic [7:0] ans;
        logic [3:0] fl;   // {carry, is_zero, negative, overflow}
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic fe);
        @(negedge clk);
        op      = o;
        a       = x;
        b       = y;
        flag_en = fe;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        issue(t.op, t.a, t.b, t.fe);
        chk($sformatf("v%0d_done", idx), 16'(done), 16'd1);
        chk($sformatf("v%0d_busy", idx), 16'(busy), 16'd0);
        chk($sformatf("v%0d_ans", idx), 16'(ans), 16'(t.ans));
        chk($sformatf("v%0d_flags", idx), 16'(flags), 16'(t.fl));
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        clr_n   = 1'b0;
        a       = '0;
        b       = '0;
        op      = '0;
        start   = 1'b0;
        en      = 1'b1;
        flag_en = 1'b0;

        vecs.push_back('{3'b000, 8'd20, 8'd10, 1'b1, 8'd30, 4'b0000});
        vecs.push_back('{3'b001, 8'd10, 8'd20, 1'b1, 8'd246, 4'b0010});
        vecs.push_back('{3'b001, 8'd20, 8'd20, 1'b1, 8'd0, 4'b1100});
        vecs.push_back('{3'b000, 8'd127, 8'd127, 1'b0, 8'd254, 4'b1100});
        vecs.push_back('{3'b000, 8'd127, 8'd127, 1'b1, 8'd254, 4'b0011});
        vecs.push_back('{3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000});
        vecs.push_back('{3'b011, 8'h81, 8'h02, 1'b1, 8'h83, 4'b0010});
        vecs.push_back('{3'b100, 8'hAA, 8'hAA, 1'b1, 8'h00, 4'b0100});
        vecs.push_back('{3'b101, 8'hC1, 8'h00, 1'b1, 8'h82, 4'b1010});
        vecs.push_back('{3'b101, 8'h40, 8'h00, 1'b1, 8'h80, 4'b0011});
        vecs.push_back('{3'b110, 8'h81, 8'h00, 1'b1, 8'h40, 4'b1000});
        vecs.push_back('{3'b000, 8'd200, 8'd100, 1'b1, 8'd44, 4'b1000});
        vecs.push_back('{3'b001, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b1001});
        vecs.push_back('{3'b000, 8'd0, 8'd0, 1'b1, 8'd0, 4'b0100});
`ifndef ALU_MUL_EN
        vecs.push_back('{3'b111, 8'd3, 8'd99, 1'b1, 8'd99, 4'b0000});
        vecs.push_back('{3'b111, 8'd3, 8'h80, 1'b1, 8'h80, 4'b0010});
`endif

        // Reset state
        #1;
        chk("rst_ans", 16'(ans), 16'd0);
        chk("rst_flags", 16'(flags), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        @(negedge clk);
        clr_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // done is a single-cycle pulse
        @(negedge clk);
        chk("done_pulse_end", 16'(done), 16'd0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        op = 3'b000; a = 8'd1; b = 8'd2; flag_en = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("b2b_done1", 16'(done), 16'd1);
        chk("b2b_ans1", 16'(ans), 16'd3);
        a = 8'd3; b = 8'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", 16'(done), 16'd1);
        chk("b2b_ans2", 16'(ans), 16'd7);
        @(negedge clk);
        chk("b2b_idle", 16'(done), 16'd0);

        // Bus enable
        en = 1'b0;
        #1;
        chk("en0_hiz", 16'(ans === 8'bzzzz_zzzz), 16'd1);
        @(negedge clk);
        en = 1'b1;
        #1;
        chk("en1_ans", 16'(ans), 16'd7);

        // Reset while done is high
        issue(3'b000, 8'd5, 8'd6, 1'b1);
        chk("pre_rst_done", 16'(done), 16'd1);
        clr_n = 1'b0;
        #1;
        chk("rst2_done", 16'(done), 16'd0);
        chk("rst2_ans", 16'(ans), 16'd0);
        chk("rst2_flags", 16'(flags), 16'd0);
        @(negedge clk);
        clr_n = 1'b1;

`ifdef ALU_MUL_EN
        // MUL 15*17 = 255, start pulse mid-multiply is ignored
        issue(3'b111, 8'd15, 8'd17, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul1_busy%0d", i), 16'(busy), 16'd1);
            chk($sformatf("mul1_ndone%0d", i), 16'(done), 16'd0);
            if (i == 3) begin
                start = 1'b1; op = 3'b000; a = 8'd1; b = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul1_done", 16'(done), 16'd1);
        chk("mul1_busy_end", 16'(busy), 16'd0);
        chk("mul1_ans", 16'(ans), 16'd255);
        chk("mul1_flags", 16'(flags), 16'b0010);

        // MUL 16*16 = 256 -> low byte 0, high half nonzero
        issue(3'b111, 8'd16, 8'd16, 1'b1);
        repeat (8) @(negedge clk);
        chk("mul2_done", 16'(done), 16'd1);
        chk("mul2_ans", 16'(ans), 16'd0);
        chk("mul2_flags", 16'(flags), 16'b1100);

        // Reset at cycle 4 of a multiply
        issue(3'b111, 8'd7, 8'd9, 1'b1);
        repeat (3) @(negedge clk);
        chk("mul3_busy", 16'(busy), 16'd1);
        clr_n = 1'b0;
        #1;
        chk("mul3_rst_ans", 16'(ans), 16'd0);
        chk("mul3_rst_busy", 16'(busy), 16'd0);
        chk("mul3_rst_flags", 16'(flags), 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done || busy) seen = 1'b1;
            end
            chk("mul3_no_done", 16'(seen), 16'd0);
        end
        issue(3'b000, 8'd8, 8'd9, 1'b1);
        chk("post_rst_done", 16'(done), 16'd1);
        chk("post_rst_ans", 16'(ans), 16'd17);
`else
        // op 111 pass-through after reset; busy never rises
        issue(3'b111, 8'd3, 8'd99, 1'b1);
        chk("pass_done", 16'(done), 16'd1);
        chk("pass_ans", 16'(ans), 16'd99);
        chk("pass_busy", 16'(busy), 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
